// File: rtl/mult_dot_sequencer.sv
// Dot-product sequencer: buffers {last,a,b} operand pairs in a small FIFO, drives an
// external 4x4 multiplier one product at a time and accumulates each vector's sum.
module mult_dot_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ACC_W        = 12,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             last,
  output logic             mul_start,
  output logic [3:0]       mul_in_1,
  output logic [3:0]       mul_in_2,
  input  logic [7:0]       mul_out,
  input  logic             mul_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum,
  output logic             overflow,
  output logic             err,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    ACCUM,
    RESULT
  } state_t;

  typedef struct packed {
    logic       last;
    logic [3:0] a;
    logic [3:0] b;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  entry_t           head;

  state_t           state;
  state_t           state_next;
  logic             issue_pop;
  logic             drop_pop;
  logic             timeout;
  logic             last_q;
  logic             discard;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       prod;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   acc_sum;

  assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !rst;
  assign pop      = issue_pop || drop_pop;
  assign head     = mem[rd_ptr];

  // Extra top bit of acc_sum is the carry out of the accumulator.
  assign acc_sum  = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign timeout  = (state == WAIT_BUSY) && mul_ready && (busy_cnt == CNT_LAST);

  assign mul_start = (state == ISSUE);
  assign sum_valid = (state == RESULT);
  assign overflow  = ovf;
  assign busy      = (state != IDLE) || !empty;

  // NOTE: storage array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last, a, b};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    issue_pop  = 1'b0;
    drop_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (discard) begin
            drop_pop = 1'b1;
          end else if (mul_ready) begin
            issue_pop  = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mul_ready)   state_next = WAIT_DONE;
        else if (timeout) state_next = IDLE;
      end
      WAIT_DONE: if (mul_ready) state_next = ACCUM;
      ACCUM:     state_next = last_q ? RESULT : IDLE;
      RESULT:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mul_in_1 <= '0;
      mul_in_2 <= '0;
      last_q   <= 1'b0;
      discard  <= 1'b0;
      busy_cnt <= '0;
      prod     <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      sum      <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (issue_pop) begin
        mul_in_1 <= head.a;
        mul_in_2 <= head.b;
        last_q   <= head.last;
      end
      if (drop_pop && head.last) discard <= 1'b0;
      case (state)
        ISSUE: busy_cnt <= '0;
        WAIT_BUSY: begin
          // A multiplier that never goes busy aborts the whole vector.
          if (timeout) begin
            err     <= 1'b1;
            acc     <= '0;
            ovf     <= 1'b0;
            discard <= !last_q;
          end else if (mul_ready) begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: if (mul_ready) prod <= mul_out;
        ACCUM: begin
          acc <= acc_sum[ACC_W-1:0];
          ovf <= ovf | acc_sum[ACC_W];
          if (last_q) sum <= acc_sum[ACC_W-1:0];
        end
        RESULT: begin
          acc <= '0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dot_sequencer.sv
// Self-checking bench for mult_dot_sequencer: behavioural multiplier, result monitor
// and an arithmetic dot-product reference for randomized vectors.
module tb_mult_dot_sequencer;

  localparam int ACC_W = 12;
  localparam int MOD   = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       a = '0;
  logic [3:0]       b = '0;
  logic             last = 1'b0;
  logic             mul_start;
  logic [3:0]       mul_in_1;
  logic [3:0]       mul_in_2;
  logic [7:0]       mul_out;
  logic             mul_ready;
  logic             sum_valid;
  logic [ACC_W-1:0] sum;
  logic             overflow;
  logic             err;
  logic             busy;

  mult_dot_sequencer #(
    .FIFO_DEPTH  (4),
    .ACC_W       (ACC_W),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .last     (last),
    .mul_start(mul_start),
    .mul_in_1 (mul_in_1),
    .mul_in_2 (mul_in_2),
    .mul_out  (mul_out),
    .mul_ready(mul_ready),
    .sum_valid(sum_valid),
    .sum      (sum),
    .overflow (overflow),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Multiplier model: ready falls the cycle after start, returns 8 cycles later with a*b.
  logic       mdl_ready_q = 1'b1;
  logic       mdl_hold = 1'b0;
  logic       mdl_never_busy = 1'b0;
  int         mdl_left = 0;
  logic [7:0] mdl_prod = '0;
  logic [7:0] mul_out_q = '0;

  assign mul_ready = mdl_ready_q && !mdl_hold;
  assign mul_out   = mul_out_q;

  always @(posedge clk) begin
    if (mul_start && mul_ready && !mdl_never_busy) begin
      mdl_ready_q <= 1'b0;
      mdl_left    <= 8;
      mdl_prod    <= 8'(mul_in_1) * 8'(mul_in_2);
    end else if (!mdl_ready_q) begin
      if (mdl_left <= 1) begin
        mdl_ready_q <= 1'b1;
        mul_out_q   <= mdl_prod;
      end else begin
        mdl_left <= mdl_left - 1;
      end
    end
  end

  typedef struct {
    int s;
    bit ov;
    int at;
  } res_t;

  res_t results[$];
  int   cyc = 0;
  int   start_cnt = 0;
  int   start_bad = 0;
  int   start_cyc = -1;
  int   rise_cyc = -1;
  int   push_cyc = -1;
  logic prev_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (sum_valid) begin
        r.s  = int'(sum);
        r.ov = overflow;
        r.at = cyc;
        results.push_back(r);
      end
      if (mul_start) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
        if (!mul_ready) start_bad <= start_bad + 1;
      end
      if (mul_ready && !prev_ready) rise_cyc <= cyc;
    end
    prev_ready <= mul_ready;
  end

  function automatic void ref_dot(input int av[$], input int bv[$], output int s, output bit ov);
    int total = 0;
    foreach (av[i]) total += av[i] * bv[i];
    s  = total % MOD;
    ov = (total >= MOD);
  endfunction

  task automatic push_pair(input logic [3:0] pa, input logic [3:0] pb, input logic pl);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = pa;
    b = pb;
    last = pl;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL push_accept: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    push_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vector(input int av[$], input int bv[$], output res_t r, output int starts,
                            output bit got);
    int base = results.size();
    int sbase = start_cnt;
    int n = 0;
    for (int i = 0; i < av.size(); i++)
      push_pair(4'(av[i]), 4'(bv[i]), i == av.size() - 1);
    while (results.size() <= base && n < 600) begin
      @(negedge clk);
      n++;
    end
    got = (results.size() > base);
    r.s = -1;
    r.ov = 1'b0;
    r.at = -100;
    if (got) r = results[base];
    repeat (2) @(negedge clk);
    starts = start_cnt - sbase;
  endtask

  task automatic test_reset();
    int base;
    int sbase;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd5;
    last = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    base = results.size();
    sbase = start_cnt;
    vectors += 9;
    if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    if (mul_start !== 1'b0) begin miscompares++; $display("FAIL reset_mul_start: got %b, want 0", mul_start); end
    if (mul_in_1 !== 4'd0)  begin miscompares++; $display("FAIL reset_mul_in_1: got %h, want 0", mul_in_1); end
    if (mul_in_2 !== 4'd0)  begin miscompares++; $display("FAIL reset_mul_in_2: got %h, want 0", mul_in_2); end
    if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sum_valid: got %b, want 0", sum_valid); end
    if (sum !== '0)         begin miscompares++; $display("FAIL reset_sum: got %0d, want 0", sum); end
    if (overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    if (err !== 1'b0)       begin miscompares++; $display("FAIL reset_err: got %b, want 0", err); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b, want 0", busy); end
    repeat (20) @(negedge clk);
    vectors += 2;
    if (start_cnt - sbase != 0) begin
      miscompares++;
      $display("FAIL reset_ignored_push_start: got %0d starts, want 0", start_cnt - sbase);
    end
    if (results.size() != base) begin
      miscompares++;
      $display("FAIL reset_ignored_push_result: got %0d results, want 0", results.size() - base);
    end
  endtask

  task automatic test_single();
    int av[$];
    int bv[$];
    res_t r;
    int starts;
    bit got;
    int pc;
    av.push_back(6);
    bv.push_back(9);
    run_vector(av, bv, r, starts, got);
    pc = push_cyc;
    vectors += 6;
    if (got !== 1'b1)  begin miscompares++; $display("FAIL single_strobe: got none, want one sum_valid"); end
    if (r.s != 54)     begin miscompares++; $display("FAIL single_sum: got %0d, want 54", r.s); end
    if (r.ov !== 1'b0) begin miscompares++; $display("FAIL single_overflow: got %b, want 0", r.ov); end
    if (starts != 1)   begin miscompares++; $display("FAIL single_starts: got %0d, want 1", starts); end
    if (start_cyc - pc != 2) begin
      miscompares++;
      $display("FAIL single_start_latency: got %0d cycles, want 2", start_cyc - pc);
    end
    if (r.at - rise_cyc != 2) begin
      miscompares++;
      $display("FAIL single_result_latency: got %0d cycles, want 2", r.at - rise_cyc);
    end
  endtask

  task automatic test_vector();
    int fa[4] = '{10, 11, 7, 15};
    int fb[4] = '{3, 5, 12, 15};
    int av[$];
    int bv[$];
    res_t r;
    int starts;
    bit got;
    foreach (fa[i]) begin
      av.push_back(fa[i]);
      bv.push_back(fb[i]);
    end
    run_vector(av, bv, r, starts, got);
    vectors += 5;
    if (r.s != 394)    begin miscompares++; $display("FAIL vector_sum: got %0d, want 394", r.s); end
    if (r.ov !== 1'b0) begin miscompares++; $display("FAIL vector_overflow: got %b, want 0", r.ov); end
    if (starts != 4)   begin miscompares++; $display("FAIL vector_starts: got %0d, want 4", starts); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL vector_busy_after: got %b, want 0", busy); end
    if (r.at - rise_cyc != 2) begin
      miscompares++;
      $display("FAIL vector_result_latency: got %0d cycles, want 2", r.at - rise_cyc);
    end
  endtask

  task automatic test_backpressure();
    int av[$];
    int bv[$];
    int exp_s;
    bit exp_ov;
    int base;
    int sbase;
    int n = 0;
    res_t r;
    r.s = -1;
    r.ov = 1'b0;
    r.at = 0;
    base = results.size();
    sbase = start_cnt;
    @(negedge clk);
    mdl_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av.push_back(int'($urandom_range(0, 15)));
      bv.push_back(int'($urandom_range(0, 15)));
      push_pair(4'(av[i]), 4'(bv[i]), i == 3);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b, want 0", in_ready); end
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd15;
    last = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_hold_in_ready: got %b, want 0", in_ready); end
    in_valid = 1'b0;
    mdl_hold = 1'b0;
    ref_dot(av, bv, exp_s, exp_ov);
    while (results.size() <= base && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (results.size() > base) r = results[base];
    repeat (30) @(negedge clk);
    vectors += 5;
    if (r.s != exp_s)    begin miscompares++; $display("FAIL stall_sum: got %0d, want %0d", r.s, exp_s); end
    if (r.ov !== exp_ov) begin miscompares++; $display("FAIL stall_overflow: got %b, want %b", r.ov, exp_ov); end
    if (start_cnt - sbase != 4) begin
      miscompares++;
      $display("FAIL stall_starts: got %0d, want 4", start_cnt - sbase);
    end
    if (results.size() != base + 1) begin
      miscompares++;
      $display("FAIL stall_result_count: got %0d, want 1", results.size() - base);
    end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_random();
    for (int v = 0; v < 6; v++) begin
      int av[$];
      int bv[$];
      int len;
      int exp_s;
      bit exp_ov;
      res_t r;
      int starts;
      bit got;
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        av.push_back(int'($urandom_range(0, 15)));
        bv.push_back(int'($urandom_range(0, 15)));
      end
      ref_dot(av, bv, exp_s, exp_ov);
      run_vector(av, bv, r, starts, got);
      vectors += 3;
      if (r.s != exp_s) begin
        miscompares++;
        $display("FAIL random_sum[%0d]: got %0d, want %0d", v, r.s, exp_s);
      end
      if (r.ov !== exp_ov) begin
        miscompares++;
        $display("FAIL random_overflow[%0d]: got %b, want %b", v, r.ov, exp_ov);
      end
      if (starts != len) begin
        miscompares++;
        $display("FAIL random_starts[%0d]: got %0d, want %0d", v, starts, len);
      end
    end
  endtask

  task automatic test_overflow();
    int av[$];
    int bv[$];
    res_t r;
    int starts;
    bit got;
    for (int i = 0; i < 19; i++) begin
      av.push_back(15);
      bv.push_back(15);
    end
    run_vector(av, bv, r, starts, got);
    vectors += 3;
    if (r.s != 179)    begin miscompares++; $display("FAIL wrap_sum: got %0d, want 179", r.s); end
    if (r.ov !== 1'b1) begin miscompares++; $display("FAIL wrap_overflow: got %b, want 1", r.ov); end
    if (starts != 19)  begin miscompares++; $display("FAIL wrap_starts: got %0d, want 19", starts); end
    av.delete();
    bv.delete();
    av.push_back(1);
    bv.push_back(2);
    run_vector(av, bv, r, starts, got);
    vectors += 2;
    if (r.s != 2)      begin miscompares++; $display("FAIL after_wrap_sum: got %0d, want 2", r.s); end
    if (r.ov !== 1'b0) begin miscompares++; $display("FAIL after_wrap_overflow: got %b, want 0", r.ov); end
  endtask

  task automatic test_timeout();
    int av[$];
    int bv[$];
    res_t r;
    int starts;
    bit got;
    int base;
    int sbase;
    int n = 0;
    base = results.size();
    sbase = start_cnt;
    mdl_never_busy = 1'b1;
    push_pair(4'd3, 4'd4, 1'b0);
    push_pair(4'd5, 4'd6, 1'b0);
    push_pair(4'd9, 4'd9, 1'b1);
    while (err !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b, want 1", err); end
    mdl_never_busy = 1'b0;
    repeat (10) @(negedge clk);
    vectors += 3;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_discard_busy: got %b, want 0", busy); end
    if (results.size() != base) begin
      miscompares++;
      $display("FAIL timeout_no_result: got %0d results, want 0", results.size() - base);
    end
    if (start_cnt - sbase != 1) begin
      miscompares++;
      $display("FAIL timeout_starts: got %0d, want 1", start_cnt - sbase);
    end
    av.push_back(2);
    bv.push_back(2);
    run_vector(av, bv, r, starts, got);
    vectors += 3;
    if (r.s != 4)      begin miscompares++; $display("FAIL post_timeout_sum: got %0d, want 4", r.s); end
    if (r.ov !== 1'b0) begin miscompares++; $display("FAIL post_timeout_overflow: got %b, want 0", r.ov); end
    if (err !== 1'b1)  begin miscompares++; $display("FAIL err_sticky: got %b, want 1", err); end
  endtask

  task automatic test_reset_wait_done();
    int av[$];
    int bv[$];
    res_t r;
    int starts;
    bit got;
    int base;
    int n = 0;
    push_pair(4'd7, 4'd7, 1'b1);
    push_pair(4'd1, 4'd1, 1'b1);
    while (mul_ready !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (mul_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wd_mul_busy: got %b, want 0", mul_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors += 5;
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_wd_busy: got %b, want 0", busy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wd_in_ready: got %b, want 1", in_ready); end
    if (err !== 1'b0)      begin miscompares++; $display("FAIL rst_wd_err: got %b, want 0", err); end
    if (sum !== '0)        begin miscompares++; $display("FAIL rst_wd_sum: got %0d, want 0", sum); end
    if (mul_in_1 !== 4'd0) begin miscompares++; $display("FAIL rst_wd_mul_in_1: got %h, want 0", mul_in_1); end
    base = results.size();
    av.push_back(2);
    bv.push_back(3);
    run_vector(av, bv, r, starts, got);
    repeat (30) @(negedge clk);
    vectors += 3;
    if (r.s != 6)      begin miscompares++; $display("FAIL rst_wd_fresh_sum: got %0d, want 6", r.s); end
    if (r.ov !== 1'b0) begin miscompares++; $display("FAIL rst_wd_fresh_overflow: got %b, want 0", r.ov); end
    if (results.size() != base + 1) begin
      miscompares++;
      $display("FAIL rst_wd_result_count: got %0d, want 1", results.size() - base);
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (start_bad != 0) begin
      miscompares++;
      $display("FAIL start_while_busy: got %0d occurrences, want 0", start_bad);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_vector();
    test_backpressure();
    test_random();
    test_overflow();
    test_timeout();
    test_reset_wait_done();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
